// File: rtl/coram_timestamp_arbiter.sv
// rtl/coram_timestamp_arbiter.sv - round-robin publisher of per-requester cycle timestamps to one CoramRegister port
//
// Ports:
//   CLK          clock
//   RST          synchronous, active-high reset
//   req          per-requester capture pulse (N_REQ bits), sampled every cycle
//   ack          control-thread acknowledge, only looked at while waiting for it
//   clear_err    clears overflow, timeout_err and drop_count
//   comm_d       CoramRegister D: {1'b1, id, timestamp}
//   comm_we      CoramRegister WE, high for exactly the one WRITE cycle
//   busy         FSM not idle or any timestamp still pending
//   overflow     sticky: a capture was dropped because its slot was still pending
//   timeout_err  sticky: an entry was abandoned after ACK_TIMEOUT cycles without ack
//   drop_count   saturating count of dropped captures plus abandoned entries
module coram_timestamp_arbiter #(
    parameter int W_D         = 32,
    parameter int N_REQ       = 4,
    parameter int W_ID        = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic             ack,
    input  logic             clear_err,
    output logic [W_D-1:0]   comm_d,
    output logic             comm_we,
    output logic             busy,
    output logic             overflow,
    output logic             timeout_err,
    output logic [7:0]       drop_count
);

    localparam int W_TS   = W_D - 1 - W_ID;
    localparam int W_WAIT = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WRITE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [W_TS-1:0]   counter;
    logic [W_TS-1:0]   ts_q [N_REQ];
    logic [N_REQ-1:0]  pending;
    logic [N_REQ-1:0]  pending_nxt;
    logic [W_ID-1:0]   rr_ptr;
    logic [W_WAIT-1:0] wait_cnt;
    logic [W_WAIT-1:0] wait_cnt_nxt;

    logic              grant_found;
    logic [W_ID-1:0]   grant_id;
    logic [W_ID-1:0]   cand;
    logic              grant;
    logic              timeout_hit;

    logic [N_REQ-1:0]  granted_vec;
    logic [N_REQ-1:0]  drop_vec;
    logic [N_REQ-1:0]  capture;

    logic [4:0]        new_errs;
    logic [7:0]        drop_base;
    logic [8:0]        drop_sum;
    logic [7:0]        drop_count_nxt;
    logic              overflow_nxt;
    logic              timeout_err_nxt;

    // Cyclic search for the first pending slot at or after rr_ptr. The W_ID-bit
    // addition wraps naturally because N_REQ is a power of two.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = rr_ptr + W_ID'(k);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // WAIT_ACK lasts at most ACK_TIMEOUT cycles: the wait counter sweeps
    // 0..ACK_TIMEOUT-1 and the entry is abandoned in the cycle it sits at the top.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        grant        = 1'b0;
        timeout_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (grant_found) begin
                    grant     = 1'b1;
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wait_cnt_nxt = '0;
                state_nxt    = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (ack) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt == W_WAIT'(ACK_TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + W_WAIT'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // A req on the slot being granted this cycle re-arms it rather than counting
    // as an overflow: the old timestamp is already on its way into comm_d.
    always_comb begin
        granted_vec = '0;
        drop_vec    = '0;
        capture     = '0;
        pending_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            granted_vec[i] = grant && (grant_id == W_ID'(i));
            drop_vec[i]    = req[i] & pending[i] & ~granted_vec[i];
            capture[i]     = req[i] & ~drop_vec[i];
            pending_nxt[i] = capture[i] | (pending[i] & ~granted_vec[i]);
        end
    end

    // Error bookkeeping: a clear in the same cycle as new errors leaves exactly
    // the new errors behind.
    always_comb begin
        new_errs = {4'b0, timeout_hit};
        for (int i = 0; i < N_REQ; i++) begin
            new_errs = new_errs + {4'b0, drop_vec[i]};
        end
        drop_base       = clear_err ? 8'd0 : drop_count;
        drop_sum        = {1'b0, drop_base} + {4'b0, new_errs};
        drop_count_nxt  = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        overflow_nxt    = (overflow & ~clear_err) | (|drop_vec);
        timeout_err_nxt = (timeout_err & ~clear_err) | timeout_hit;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            counter     <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            comm_d      <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
            drop_count  <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            counter     <= counter + W_TS'(1);
            pending     <= pending_nxt;
            wait_cnt    <= wait_cnt_nxt;
            overflow    <= overflow_nxt;
            timeout_err <= timeout_err_nxt;
            drop_count  <= drop_count_nxt;
            for (int i = 0; i < N_REQ; i++) begin
                if (capture[i]) begin
                    ts_q[i] <= counter;
                end
            end
            if (grant) begin
                comm_d <= {1'b1, grant_id, ts_q[grant_id]};
                rr_ptr <= grant_id + W_ID'(1);
            end
        end
    end

    assign comm_we = (state == S_WRITE);
    assign busy    = (state != S_IDLE) | (|pending);

endmodule

// File: tb/tb_coram_timestamp_arbiter.sv
// tb/tb_coram_timestamp_arbiter.sv - directed self-checking bench for coram_timestamp_arbiter
module tb_coram_timestamp_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  req;
    logic        ack;
    logic        clear_err;
    logic [31:0] comm_d;
    logic        comm_we;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
    logic [7:0]  drop_count;

    // Narrow instance (5-bit timestamp) so counter wrap is reachable quickly.
    logic [3:0]  req_s;
    logic        ack_s;
    logic [7:0]  comm_d_s;
    logic        comm_we_s;
    logic        busy_s;
    logic        overflow_s;
    logic        timeout_err_s;
    logic [7:0]  drop_count_s;

    int cnt;
    int chk_cnt;
    int err_cnt;

    coram_timestamp_arbiter #(
        .W_D(32), .N_REQ(4), .W_ID(2), .ACK_TIMEOUT(16)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .ack(ack), .clear_err(clear_err),
        .comm_d(comm_d), .comm_we(comm_we), .busy(busy), .overflow(overflow),
        .timeout_err(timeout_err), .drop_count(drop_count)
    );

    coram_timestamp_arbiter #(
        .W_D(8), .N_REQ(4), .W_ID(2), .ACK_TIMEOUT(4)
    ) dut_s (
        .CLK(CLK), .RST(RST), .req(req_s), .ack(ack_s), .clear_err(1'b0),
        .comm_d(comm_d_s), .comm_we(comm_we_s), .busy(busy_s), .overflow(overflow_s),
        .timeout_err(timeout_err_s), .drop_count(drop_count_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // cnt tracks the value the DUT counter holds in the current cycle.
    task automatic tick();
        @(posedge CLK);
        if (RST) cnt = 0;
        else     cnt = cnt + 1;
        #1;
    endtask

    task automatic run_to(input int c);
        while (cnt < c) tick();
    endtask

    task automatic do_reset();
        RST = 1'b1; req = '0; ack = 1'b0; clear_err = 1'b0; req_s = '0; ack_s = 1'b0;
        tick(); tick();
        RST = 1'b0;
    endtask

    task automatic wait_we(input string tag, input int max_cycles);
        int n = 0;
        while (!comm_we && n < max_cycles) begin
            tick();
            n++;
        end
        check_val({tag, "_we"}, {31'b0, comm_we}, 32'd1);
    endtask

    task automatic publish(input string tag, input logic [31:0] exp_d, input int exp_cyc);
        wait_we(tag, 6);
        check_val({tag, "_cyc"}, cnt, exp_cyc);
        check_val(tag, comm_d, exp_d);
        tick(); ack = 1'b1;
        tick(); ack = 1'b0;
    endtask

    initial begin
        chk_cnt = 0;
        err_cnt = 0;
        cnt     = 0;

        // Reset state
        do_reset();
        check_val("rst_we",    {31'b0, comm_we}, 32'd0);
        check_val("rst_d",     comm_d, 32'd0);
        check_val("rst_busy",  {31'b0, busy}, 32'd0);
        check_val("rst_ovf",   {31'b0, overflow}, 32'd0);
        check_val("rst_tmo",   {31'b0, timeout_err}, 32'd0);
        check_val("rst_drop",  {24'b0, drop_count}, 32'd0);

        // Lone request at counter 10, two-cycle latency, ack three cycles later
        run_to(10); req = 4'b0001;
        tick(); req = '0;
        check_val("t1_we_c11",   {31'b0, comm_we}, 32'd0);
        check_val("t1_busy_c11", {31'b0, busy}, 32'd1);
        tick();
        check_val("t1_we_c12", {31'b0, comm_we}, 32'd1);
        check_val("t1_d_c12",  comm_d, 32'h8000_000A);
        tick();
        check_val("t1_we_c13", {31'b0, comm_we}, 32'd0);
        check_val("t1_hold",   comm_d, 32'h8000_000A);
        tick(); tick(); ack = 1'b1;
        tick(); ack = 1'b0;
        check_val("t1_busy_end", {31'b0, busy}, 32'd0);

        // All four at counter 100, ack one cycle after each write
        do_reset();
        run_to(100); req = 4'b1111;
        tick(); req = '0;
        publish("t2_id0", 32'h8000_0064, 102);
        publish("t2_id1", 32'hA000_0064, 105);
        publish("t2_id2", 32'hC000_0064, 108);
        publish("t2_id3", 32'hE000_0064, 111);
        check_val("t2_busy_end", {31'b0, busy}, 32'd0);

        // rr_ptr back at 0: id0 ahead of id3
        req = 4'b1001;
        tick(); req = '0;
        publish("t2_rr0_id0", 32'h8000_0071, 115);
        publish("t2_rr0_id3", 32'hE000_0071, 118);

        // Move rr_ptr to 2, then id3 wins over id0
        req = 4'b0010;
        tick(); req = '0;
        publish("t3_id1",    32'hA000_0078, 122);
        req = 4'b1001;
        tick(); req = '0;
        publish("t3_rr2_id3", 32'hE000_007C, 126);
        publish("t3_rr2_id0", 32'h8000_007C, 129);

        // Overflow: slot 1 captured at 5, re-requested at 8 while still pending
        do_reset();
        run_to(3); req = 4'b0001;
        tick(); req = '0;
        tick(); req = 4'b0010;
        check_val("t4_we_id0", {31'b0, comm_we}, 32'd1);
        check_val("t4_d_id0",  comm_d, 32'h8000_0003);
        tick(); req = '0;
        tick();
        tick(); req = 4'b0010;
        tick(); req = '0;
        check_val("t4_ovf",  {31'b0, overflow}, 32'd1);
        check_val("t4_drop", {24'b0, drop_count}, 32'd1);
        ack = 1'b1;
        tick(); ack = 1'b0;
        publish("t4_id1_keep_ts5", 32'hA000_0005, 11);
        clear_err = 1'b1;
        tick(); clear_err = 1'b0;
        check_val("t4_clr_ovf",  {31'b0, overflow}, 32'd0);
        check_val("t4_clr_drop", {24'b0, drop_count}, 32'd0);

        // Grant and req on the same slot in the same cycle: re-arm, no overflow
        req = 4'b0100;
        tick();
        tick(); req = '0;
        check_val("t4_rearm_ovf",  {31'b0, overflow}, 32'd0);
        check_val("t4_rearm_drop", {24'b0, drop_count}, 32'd0);
        publish("t4_rearm_old", 32'hC000_000E, 16);
        publish("t4_rearm_new", 32'hC000_000F, 19);
        check_val("t4_busy_end", {31'b0, busy}, 32'd0);

        // Timeout: id0 abandoned after 16 WAIT_ACK cycles, id2 follows
        req = 4'b0101;
        tick(); req = '0;
        tick();
        check_val("t5_d_id0", comm_d, 32'h8000_0015);
        run_to(39);
        check_val("t5_tmo_c39", {31'b0, timeout_err}, 32'd0);
        check_val("t5_busy_c39", {31'b0, busy}, 32'd1);
        tick();
        check_val("t5_tmo_c40",  {31'b0, timeout_err}, 32'd1);
        check_val("t5_drop_c40", {24'b0, drop_count}, 32'd1);
        check_val("t5_we_c40",   {31'b0, comm_we}, 32'd0);
        tick();
        check_val("t5_we_c41", {31'b0, comm_we}, 32'd1);
        check_val("t5_d_id2",  comm_d, 32'hC000_0015);

        // clear_err in the very cycle of a second timeout: new error wins
        run_to(57); clear_err = 1'b1;
        tick(); clear_err = 1'b0;
        check_val("t5_clrnew_tmo",  {31'b0, timeout_err}, 32'd1);
        check_val("t5_clrnew_drop", {24'b0, drop_count}, 32'd1);
        clear_err = 1'b1;
        tick(); clear_err = 1'b0;
        check_val("t5_clr_tmo",  {31'b0, timeout_err}, 32'd0);
        check_val("t5_clr_drop", {24'b0, drop_count}, 32'd0);
        check_val("t5_clr_ovf",  {31'b0, overflow}, 32'd0);

        // ack in WRITE ignored; ack on the last WAIT_ACK cycle beats the timeout
        req = 4'b0001;
        tick(); req = '0;
        tick();
        check_val("t5_d_c61", comm_d, 32'h8000_003B);
        ack = 1'b1;
        tick(); ack = 1'b0;
        check_val("t5_ack_in_write", {31'b0, busy}, 32'd1);
        run_to(77); ack = 1'b1;
        tick(); ack = 1'b0;
        check_val("t5_race_tmo",  {31'b0, timeout_err}, 32'd0);
        check_val("t5_race_drop", {24'b0, drop_count}, 32'd0);
        check_val("t5_race_busy", {31'b0, busy}, 32'd0);

        // Counter wrap on the 5-bit instance: ts 31 then ts 0
        run_to(95); req_s = 4'b0001;
        tick(); req_s = 4'b0010;
        tick(); req_s = '0;
        check_val("t6_we_s_31", {31'b0, comm_we_s}, 32'd1);
        check_val("t6_d_s_31",  {24'b0, comm_d_s}, 32'h9F);
        tick(); ack_s = 1'b1;
        tick(); ack_s = 1'b0;
        tick();
        check_val("t6_we_s_0", {31'b0, comm_we_s}, 32'd1);
        check_val("t6_d_s_0",  {24'b0, comm_d_s}, 32'hA0);
        tick(); ack_s = 1'b1;
        tick(); ack_s = 1'b0;
        check_val("t6_busy_s", {31'b0, busy_s}, 32'd0);

        // Reset during WAIT_ACK drops everything
        req = 4'b0011;
        tick(); req = '0;
        tick();
        check_val("t7_we", {31'b0, comm_we}, 32'd1);
        check_val("t7_d",  comm_d, 32'hA000_0066);
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        check_val("t7_rst_we",   {31'b0, comm_we}, 32'd0);
        check_val("t7_rst_busy", {31'b0, busy}, 32'd0);
        check_val("t7_rst_d",    comm_d, 32'd0);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick();
                if (comm_we) seen = 1'b1;
            end
            check_val("t7_no_write", {31'b0, seen}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
